// File: rtl/rps_sprite_draw_sched.sv
// Arbitrates two players' sprite draws onto the 160x120 VGA write port.
// Ports: CLOCK_50/reset; req/ack/busy handshake; choice0/1; rom_addr + q_*; x/y/colour/plot.
module rps_sprite_draw_sched #(
  parameter int SPR_W = 64,
  parameter int SPR_H = 64,
  parameter int AW    = 12,
  parameter int X0_P0 = 8,
  parameter int Y0_P0 = 28,
  parameter int X0_P1 = 88,
  parameter int Y0_P1 = 28
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    choice0,
  input  logic [1:0]    choice1,
  output logic [1:0]    ack,
  output logic          busy,
  output logic [AW-1:0] rom_addr,
  input  logic          q_rock,
  input  logic          q_scissor,
  input  logic          q_paper,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic [2:0]    colour,
  output logic          plot
);

  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t        state;
  state_t        state_n;
  logic          rr;
  logic          player;
  logic          gnt_p;
  logic [1:0]    choice_l;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic          last_px;
  logic [7:0]    x0;
  logic [6:0]    y0;
  logic          q_sel;
  logic          pix;

  assign last_px = (sx == XW'(SPR_W - 1)) && (sy == YW'(SPR_H - 1));
  assign x0 = player ? 8'(X0_P1) : 8'(X0_P0);
  assign y0 = player ? 7'(Y0_P1) : 7'(Y0_P0);
  assign rom_addr = AW'(sy) * AW'(SPR_W) + AW'(sx);

  // Contention goes to the player that was not served last.
  always_comb begin
    gnt_p = req[1];
    if (req == 2'b11) gnt_p = ~rr;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req) state_n = DRAW;
      DRAW:    if (last_px) state_n = FLUSH;
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rr       <= 1'b1;
      player   <= 1'b0;
      choice_l <= 2'b00;
      sx       <= '0;
      sy       <= '0;
      plot     <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      // One-stage tag tracking the address issued this cycle.
      plot <= (state == DRAW);
      if (state == DRAW) begin
        x <= x0 + 8'(sx);
        y <= y0 + 7'(sy);
      end
      if (state == IDLE && |req) begin
        player   <= gnt_p;
        rr       <= gnt_p;
        choice_l <= gnt_p ? choice1 : choice0;
        sx       <= '0;
        sy       <= '0;
      end else if (state == DRAW && !last_px) begin
        if (sx == XW'(SPR_W - 1)) begin
          sx <= '0;
          sy <= sy + YW'(1);
        end else begin
          sx <= sx + XW'(1);
        end
      end
    end
  end

  always_comb begin
    busy = (state != IDLE);
    ack  = 2'b00;
    if (state == DONE) ack = player ? 2'b10 : 2'b01;
    unique case (choice_l)
      2'b00:   q_sel = q_rock;
      2'b01:   q_sel = q_scissor;
      default: q_sel = q_paper;
    endcase
    // Player 1's sprite is drawn in inverse video.
    pix    = player ? ~q_sel : q_sel;
    colour = (plot && pix) ? 3'b111 : 3'b000;
  end

endmodule
